prbschk_ctl: RTL and testbench

BER test controller that sequences a PRBS data monitor.
- On `start`, waits for pattern lock: SYNCNUM consecutive clean words.
- Then measures a programmed window of valid words, counting PRBS errors and, optionally, parity errors.
- Issues a one-cycle `done` with a `pass` verdict.
- Sits beside the monitor in the test/diagnostic path and is driven by the software-facing register block.

---
 rtl/prbschk_ctl.sv | 150 +++++++++++++++
 tb/tb_prbschk_ctl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbschk_ctl.sv
// prbschk_ctl: BER test controller sequencing a PRBS monitor (lock, windowed error count, verdict).
// Define PRBSCHK_CTL_PARCNT_EN to count delayed parity errors and fold them into the verdict.
module prbschk_ctl #(
    parameter int CNTW    = 16,
    parameter int WINW    = 24,
    parameter int SYNCNUM = 8
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            start,
    input  logic            abort,
    input  logic [WINW-1:0] winlen,
    input  logic [CNTW-1:0] errthr,
    input  logic            mval,
    input  logic            errprbs,
    input  logic            errpar,
    output logic            busy,
    output logic            locked,
    output logic            done,
    output logic            pass,
    output logic            lossync,
    output logic [CNTW-1:0] prbscnt,
    output logic [CNTW-1:0] parcnt
);
    typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, DONE} state_t;
    localparam logic [7:0]      SYNC_LAST = 8'(SYNCNUM - 1);
    localparam logic [WINW-1:0] ONE_W     = 1;
    localparam logic [CNTW-1:0] ONE_C     = 1;
    state_t          state_q, state_d;
    logic [7:0]      run_q, run_d;
    logic [WINW-1:0] win_q, win_d, winlen_q, winlen_d;
    logic [CNTW-1:0] thr_q, thr_d, prbs_q, prbs_d, par_q, par_d, par_nx;
    logic            loss_q, loss_d, pass_q, pass_d;
    logic            go, lock_hit, loss_hit, win_hit, par_hit, par_ok;

    assign go       = start & ~abort & (state_q == IDLE);
    assign lock_hit = mval & ~errprbs & (run_q == SYNC_LAST);
    assign loss_hit = mval & errprbs & (run_q == SYNC_LAST);
    assign win_hit  = mval & (winlen_q != '0) & ((win_q + ONE_W) == winlen_q);
    assign par_nx   = (par_hit && par_q != '1) ? par_q + ONE_C : par_q;

`ifdef PRBSCHK_CTL_PARCNT_EN
    logic pmval_q, prun_q;
    // one-cycle delay of word-valid and RUN so the lagging parity flag is qualified by its own word
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pmval_q <= 1'b0;
            prun_q  <= 1'b0;
        end else begin
            pmval_q <= mval;
            prun_q  <= (state_q == RUN);
        end
    end
    assign par_hit = errpar & pmval_q & prun_q & ~abort & (state_q == RUN || state_q == DRAIN);
    assign par_ok  = (par_nx <= thr_q);
`else
    logic unused_par;
    assign unused_par = errpar;
    assign par_hit    = 1'b0;
    assign par_ok     = 1'b1;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: abort beats everything outside IDLE; DRAIN and DONE last one cycle each
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = go ? SYNC : IDLE;
        else if (abort) state_d = IDLE;
        else if (state_q == SYNC) state_d = lock_hit ? RUN : SYNC;
        else if (state_q == RUN) state_d = win_hit ? DRAIN : (loss_hit ? SYNC : RUN);
        else if (state_q == DRAIN) state_d = DONE;
        else state_d = IDLE;
    end

    // datapath registers: counters, latched config, sticky flags, verdict
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            run_q    <= '0;
            win_q    <= '0;
            winlen_q <= '0;
            thr_q    <= '0;
            prbs_q   <= '0;
            par_q    <= '0;
            loss_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            run_q    <= run_d;
            win_q    <= win_d;
            winlen_q <= winlen_d;
            thr_q    <= thr_d;
            prbs_q   <= prbs_d;
            par_q    <= par_d;
            loss_q   <= loss_d;
            pass_q   <= pass_d;
        end
    end

    // datapath next values; run_q counts clean words in SYNC and errored words in RUN
    always_comb begin
        run_d    = run_q;
        win_d    = win_q;
        winlen_d = winlen_q;
        thr_d    = thr_q;
        prbs_d   = prbs_q;
        par_d    = par_q;
        loss_d   = loss_q;
        pass_d   = pass_q;
        if (go) begin
            run_d    = '0;
            win_d    = '0;
            winlen_d = winlen;
            thr_d    = errthr;
            prbs_d   = '0;
            par_d    = '0;
            loss_d   = 1'b0;
            pass_d   = 1'b0;
        end else if (abort && state_q != IDLE) begin
            pass_d = 1'b0;
        end else begin
            if (state_q == SYNC && mval) run_d = (lock_hit || errprbs) ? '0 : run_q + 8'd1;
            if (state_q == RUN && mval) begin
                win_d  = win_q + ONE_W;
                run_d  = (!errprbs || loss_hit) ? '0 : run_q + 8'd1;
                prbs_d = (errprbs && prbs_q != '1) ? prbs_q + ONE_C : prbs_q;
                loss_d = loss_q | loss_hit;
            end
            par_d = par_nx;
            if (state_q == DRAIN) pass_d = (prbs_q <= thr_q) && !loss_q && par_ok;
        end
    end

    // outputs decoded from state and registers
    always_comb begin
        busy    = (state_q != IDLE);
        locked  = (state_q == RUN);
        done    = (state_q == DONE);
        pass    = pass_q;
        lossync = loss_q;
        prbscnt = prbs_q;
        parcnt  = par_q;
    end
endmodule

// File: tb/tb_prbschk_ctl.sv
// tb_prbschk_ctl: directed bench with a done-triggered scoreboard for prbschk_ctl.
module tb_prbschk_ctl;
    localparam int SN = 8;
`ifdef PRBSCHK_CTL_PARCNT_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    logic        clk = 0, rst_ = 0, start = 0, abort = 0, mval = 0, errprbs = 0, errpar = 0;
    logic [23:0] winlen = '0;
    logic [15:0] errthr = '0;
    logic        busy, locked, done, pass, lossync;
    logic [15:0] prbscnt, parcnt;
    logic        s_busy, s_locked, s_done, s_pass, s_lossync;
    logic [3:0]  s_prbscnt, s_parcnt;
    int          total = 0, bad = 0;
    logic        par_next = 0;
    typedef struct {
        logic        pass;
        logic [15:0] prbs;
        logic [15:0] par;
        logic        loss;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    prbschk_ctl u_dut (
        .clk(clk), .rst_(rst_), .start(start), .abort(abort), .winlen(winlen), .errthr(errthr),
        .mval(mval), .errprbs(errprbs), .errpar(errpar), .busy(busy), .locked(locked),
        .done(done), .pass(pass), .lossync(lossync), .prbscnt(prbscnt), .parcnt(parcnt)
    );

    prbschk_ctl #(.CNTW(4)) u_sat (
        .clk(clk), .rst_(rst_), .start(start), .abort(abort), .winlen(winlen), .errthr(errthr[3:0]),
        .mval(mval), .errprbs(errprbs), .errpar(errpar), .busy(s_busy), .locked(s_locked),
        .done(s_done), .pass(s_pass), .lossync(s_lossync), .prbscnt(s_prbscnt), .parcnt(s_parcnt)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic push(input logic p, input int prbs, input int par, input logic loss);
        exp_t e;
        e.pass = p;
        e.prbs = 16'(prbs);
        e.par  = 16'(par);
        e.loss = loss;
        sb.push_back(e);
    endtask

    // one clock: errpar carries the parity flag queued by the previous word
    task automatic cyc(input logic m, input logic e, input logic pe);
        mval    = m;
        errprbs = e;
        errpar  = par_next;
        par_next = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input int wl, input int thr);
        winlen = 24'(wl);
        errthr = 16'(thr);
        start  = 1;
        cyc(0, 0, 0);
        start  = 0;
        chk("busy_after_start", busy, 1);
        chk("pass_cleared", pass, 0);
    endtask

    task automatic lock(input logic pe);
        repeat (SN - 1) cyc(1, 0, 0);
        chk("not_locked_early", locked, 0);
        cyc(1, 0, pe);
        chk("locked", locked, 1);
    endtask

    task automatic words(input int n, input int every, input int maxe, input logic last_pe);
        int   ne;
        logic e;
        ne = 0;
        for (int i = 0; i < n; i++) begin
            e = (every != 0) && (i % every == every - 1) && (ne < maxe);
            if (e) ne++;
            cyc(1, e, (i == n - 1) ? last_pe : 1'b0);
        end
    endtask

    task automatic finish_win();
        chk("drain_no_done", done, 0);
        chk("drain_busy", busy, 1);
        cyc(0, 0, 0);
        chk("done_pulse", done, 1);
        cyc(0, 0, 0);
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    // scoreboard monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = sb.pop_front();
                    chk("sb_pass", pass, e.pass);
                    chk("sb_prbscnt", prbscnt, e.prbs);
                    chk("sb_parcnt", parcnt, e.par);
                    chk("sb_lossync", lossync, e.loss);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_lossync", lossync, 0);
        chk("rst_prbscnt", prbscnt, 0);
        chk("rst_parcnt", parcnt, 0);
        rst_ = 1;
        cyc(0, 0, 0);
        // clean window
        begin_test(100, 0);
        lock(0);
        push(1, 0, 0, 0);
        words(100, 0, 0, 0);
        finish_win();
        // three isolated errors, threshold 2 then 3
        begin_test(100, 2);
        lock(0);
        push(0, 3, 0, 0);
        words(100, 10, 3, 0);
        finish_win();
        begin_test(100, 3);
        lock(0);
        push(1, 3, 0, 0);
        words(100, 10, 3, 0);
        finish_win();
        repeat (3) cyc(0, 0, 0);
        chk("pass_held", pass, 1);
        // loss of lock and relock, window continues
        begin_test(100, 0);
        lock(0);
        words(10, 0, 0, 0);
        repeat (SN - 1) cyc(1, 1, 0);
        chk("still_locked", locked, 1);
        cyc(1, 1, 0);
        chk("lock_dropped", locked, 0);
        chk("lossync_set", lossync, 1);
        chk("loss_prbscnt", prbscnt, 8);
        lock(0);
        push(0, 8, 0, 1);
        words(82, 0, 0, 0);
        finish_win();
        // saturation: 20 spaced errors on a 4-bit counter
        begin_test(100, 0);
        lock(0);
        push(0, 20, 0, 0);
        words(100, 4, 20, 0);
        finish_win();
        chk("sat_prbscnt", s_prbscnt, 15);
        // abort mid-RUN, then start+abort together
        begin_test(100, 0);
        lock(0);
        words(30, 5, 100, 0);
        chk("pre_abort_prbscnt", prbscnt, 6);
        abort = 1;
        cyc(0, 0, 0);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_locked", locked, 0);
        chk("abort_pass", pass, 0);
        chk("abort_prbscnt_frozen", prbscnt, 6);
        repeat (5) cyc(0, 0, 0);
        start = 1;
        abort = 1;
        cyc(0, 0, 0);
        start = 0;
        abort = 0;
        chk("start_abort_idle", busy, 0);
        // parity after the final word; parity after the lock word must be ignored
        begin_test(100, 0);
        lock(1);
        push(!PAR_EN, 0, PAR_EN ? 1 : 0, 0);
        words(100, 0, 0, 1);
        finish_win();
        chk("parcnt_final", parcnt, PAR_EN ? 1 : 0);
        // asynchronous reset mid-test
        begin_test(100, 0);
        lock(0);
        words(5, 1, 3, 0);
        chk("pre_rst_prbscnt", prbscnt, 3);
        #2 rst_ = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_prbscnt", prbscnt, 0);
        @(posedge clk);
        #1 rst_ = 1;
        cyc(0, 0, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
